xor64_descrambler: RTL

- Streaming 64-bit keystream descrambler. Receiver end of the team's XOR scrambling link.
- Each accepted word is XORed with the current state of a 64-bit Galois LFSR. The LFSR then advances one step.
- Feeding the output of an identically seeded scrambler into this block returns the original plaintext.
- Sits between the 64-bit datapath bus and downstream consumers, with valid/ready handshakes on both sides.

---
 rtl/xor64_descrambler.sv | 84 ++++++++
 1 files changed

// File: rtl/xor64_descrambler.sv
// Streaming 64-bit keystream descrambler: each accepted word is XORed with a
// Galois LFSR state, which then advances one step. valid/ready on both sides.
module xor64_descrambler #(
    parameter int unsigned      WIDTH    = 64,
    parameter logic [WIDTH-1:0] POLY     = 64'hD800000000000000,
    parameter logic [WIDTH-1:0] DEF_SEED = 64'h0000000000000001
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    seed_load,
    input  logic        [WIDTH-1:0] seed_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data,
    output logic        [15:0]      word_count,
    output logic                    OF_FLAG
);

    typedef enum logic {
        UNSEEDED = 1'b0,
        RUN      = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] lfsr, lfsr_next;
    logic [WIDTH-1:0] lfsr_step;
    logic             accept;

    assign lfsr_step = {1'b0, lfsr[WIDTH-1:1]} ^ (lfsr[0] ? POLY : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= UNSEEDED;
        end else begin
            state <= state_next;
        end
    end

    // The seed load wins over an accept in the same cycle; the word waits a cycle.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        accept     = 1'b0;
        lfsr_next  = lfsr;
        if (state == RUN && !seed_load && (!out_valid || out_ready)) begin
            in_ready = 1'b1;
        end
        accept = in_valid && in_ready;
        if (seed_load) begin
            state_next = RUN;
            lfsr_next  = (seed_in == '0) ? DEF_SEED : seed_in;
        end else if (accept) begin
            lfsr_next = lfsr_step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr       <= DEF_SEED;
            out_valid  <= 1'b0;
            out_data   <= '0;
            word_count <= '0;
        end else begin
            lfsr <= lfsr_next;
            if (accept) begin
                out_data  <= in_data ^ lfsr;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (seed_load) begin
                word_count <= '0;
            end else if (accept) begin
                word_count <= word_count + 16'd1;
            end
        end
    end

    assign OF_FLAG = 1'b0;

endmodule
